// File: rtl/alarm_clk_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_clk_btn_ctrl
//  Purpose  : Avalon-MM button controller for the alarm clock front panel.
//             Synchronises, debounces and auto-repeats up to WIDTH active-low
//             push buttons, latches press events and raises a level irq.
//  Revision : 1.0 - initial release
// ============================================================================
module alarm_clk_btn_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int c_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int c_MAX_P = (c_MAX_A > REPEAT_RATE) ? c_MAX_A : REPEAT_RATE;
    localparam int c_CNT_W = $clog2(c_MAX_P + 1);

    localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RD_LAST = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_RR_LAST = c_CNT_W'(REPEAT_RATE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [31-WIDTH:0]  c_PAD     = '0;

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_DB_PRESS = 3'd1;
    localparam logic [2:0] c_S_HELD     = 3'd2;
    localparam logic [2:0] c_S_REPEAT   = 3'd3;
    localparam logic [2:0] c_S_DB_REL   = 3'd4;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_pressed;
    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_repeat_en;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] w_w1c;
    logic             w_unused;

    // Upper write-data bits have no storage behind them.
    assign w_unused = &{1'b0, writedata[31:WIDTH]};

    // Two-flop synchroniser on the raw pins; reset parks it at "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_btn
            logic [2:0]         r_state;
            logic [2:0]         w_state_nxt;
            logic [c_CNT_W-1:0] r_cnt;
            logic [c_CNT_W-1:0] w_cnt_nxt;
            logic               r_db;
            logic               w_db_nxt;
            logic               r_evt;
            logic               w_evt_nxt;

            // Per-button state, counter, debounced level and event pulse registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= c_S_IDLE;
                    r_cnt   <= '0;
                    r_db    <= 1'b0;
                    r_evt   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_db    <= w_db_nxt;
                    r_evt   <= w_evt_nxt;
                end
            end

            // Debounce / auto-repeat next-state logic; release always takes priority.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_db_nxt    = r_db;
                w_evt_nxt   = 1'b0;
                case (r_state)
                    c_S_IDLE: begin
                        if (w_pressed[gi]) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_S_DB_PRESS;
                        end
                    end
                    c_S_DB_PRESS: begin
                        if (!w_pressed[gi]) begin
                            w_state_nxt = c_S_IDLE;
                        end else if (r_cnt == c_DB_LAST) begin
                            w_state_nxt = c_S_HELD;
                            w_db_nxt    = 1'b1;
                            w_evt_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                    c_S_HELD: begin
                        if (!w_pressed[gi]) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_S_DB_REL;
                        end else if (r_repeat_en[gi] && (r_cnt == c_RD_LAST)) begin
                            w_evt_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_S_REPEAT;
                        end else if (r_cnt != c_RD_LAST) begin
                            // Parks at the delay threshold when repeat is off so a long hold cannot wrap.
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                    c_S_REPEAT: begin
                        if (!w_pressed[gi]) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_S_DB_REL;
                        end else if (!r_repeat_en[gi]) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_S_HELD;
                        end else if (r_cnt == c_RR_LAST) begin
                            w_evt_nxt = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                    c_S_DB_REL: begin
                        if (w_pressed[gi]) begin
                            // Bounce during release: back to held, restart repeat delay, no new press.
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_S_HELD;
                        end else if (r_cnt == c_DB_LAST) begin
                            w_state_nxt = c_S_IDLE;
                            w_db_nxt    = 1'b0;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = c_S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end

            assign w_db[gi]  = r_db;
            assign w_evt[gi] = r_evt;
        end
    endgenerate

    assign w_w1c = (write && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    // Control registers and edge capture; a same-cycle event beats the W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask  <= '0;
            r_repeat_en <= '0;
            r_edge_cap  <= '0;
        end else begin
            if (write && (address == 2'd1)) r_irq_mask  <= writedata[WIDTH-1:0];
            if (write && (address == 2'd2)) r_repeat_en <= writedata[WIDTH-1:0];
            r_edge_cap <= (r_edge_cap & ~w_w1c) | w_evt;
        end
    end

    // Registered read mux (latency 1) and registered level interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            case (address)
                2'd0:    readdata <= {c_PAD, w_db};
                2'd1:    readdata <= {c_PAD, r_irq_mask};
                2'd2:    readdata <= {c_PAD, r_repeat_en};
                default: readdata <= {c_PAD, r_edge_cap};
            endcase
            irq <= |(r_edge_cap & r_irq_mask);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_clk_btn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_clk_btn_ctrl
//  Purpose  : Directed self-checking bench for alarm_clk_btn_ctrl with an
//             expected-event scoreboard (visible cycle of each capture).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_clk_btn_ctrl;

    localparam int WIDTH = 4;
    localparam int DB    = 4;
    localparam int RD    = 20;
    localparam int RR    = 8;
    localparam int HOLD  = 52;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] btn_n = '1;
    logic [1:0]       address = 2'd0;
    logic             write = 1'b0;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic             irq;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    alarm_clk_btn_ctrl #(
        .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .address(address),
        .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    // Expected visible cycles (capture edge + 1) for a press seen at edge t0 and released at edge tr.
    task automatic push_events(input int t0, input int tr, input bit rep);
        int e;
        e = t0 + 2 + DB + 1;
        exp_q.push_back(e + 1);
        if (rep) begin
            e = e + RD;
            while (e <= tr + 2) begin
                exp_q.push_back(e + 1);
                e = e + RR;
            end
        end
    endtask

    // Watches EDGE_CAPTURE bit b for n cycles, scoring and W1C-clearing each new event.
    task automatic watch(input int n, input int b);
        logic prev;
        address = 2'd3;
        prev = readdata[b];
        for (int i = 0; i < n; i++) begin
            tick();
            write = 1'b0;
            if (readdata[b] && !prev) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_event_b%0d", b), 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("event_cycle_b%0d", b), 32'(cyc), 32'(exp_q.pop_front()));
                end
                writedata = 32'd1 << b;
                write = 1'b1;
            end
            prev = readdata[b];
        end
        write = 1'b0;
    endtask

    task automatic sb_empty(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] d;
        int t0, tr;

        // 1: reset values
        repeat (3) tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check($sformatf("reset_reg%0d", a), d, 32'h0);
        end
        check("reset_irq", {31'd0, irq}, 32'd0);

        // 2: single press, latency, irq, W1C
        wr(2'd1, 32'h1);
        address = 2'd3;
        tick();
        btn_n = 4'b1110;
        t0 = cyc + 1;
        for (int i = 0; i < 20 && cyc < t0 + 7; i++) tick();
        check("cap_before", readdata, 32'h0);
        check("irq_before", {31'd0, irq}, 32'd0);
        tick();
        check("cap_set", readdata, 32'h1);
        check("irq_set", {31'd0, irq}, 32'd1);
        rd(2'd0, d);
        check("data_pressed", d, 32'h1);
        address = 2'd3; writedata = 32'h1; write = 1'b1;
        tick();
        write = 1'b0;
        check("irq_hold_clear_edge", {31'd0, irq}, 32'd1);
        tick();
        check("irq_dropped", {31'd0, irq}, 32'd0);
        check("cap_cleared", readdata, 32'h0);
        btn_n = '1;
        repeat (12) tick();
        rd(2'd0, d);
        check("data_released", d, 32'h0);
        check("irq_after_release", {31'd0, irq}, 32'd0);

        // 3: bounce on button 1
        btn_n[1] = 1'b0; tick(); tick();
        btn_n[1] = 1'b1; tick();
        btn_n[1] = 1'b0; tick(); tick();
        btn_n[1] = 1'b1;
        watch(12, 1);
        rd(2'd0, d);
        check("bounce_data", d, 32'h0);
        rd(2'd3, d);
        check("bounce_cap", d, 32'h0);

        // 4: auto-repeat on button 2, then with repeat disabled
        wr(2'd2, 32'h4);
        address = 2'd3;
        tick();
        t0 = cyc + 1;
        push_events(t0, t0 + HOLD, 1'b1);
        check("repeat_expected_count", 32'(exp_q.size()), 32'd5);
        btn_n[2] = 1'b0;
        watch(HOLD, 2);
        btn_n[2] = 1'b1;
        watch(16, 2);
        sb_empty("repeat_all_seen");
        wr(2'd2, 32'h0);
        address = 2'd3;
        tick();
        t0 = cyc + 1;
        push_events(t0, t0 + HOLD, 1'b0);
        btn_n[2] = 1'b0;
        watch(HOLD, 2);
        btn_n[2] = 1'b1;
        watch(16, 2);
        sb_empty("norepeat_all_seen");

        // 5: re-press glitch during release debounce on button 3
        address = 2'd3;
        tick();
        t0 = cyc + 1;
        push_events(t0, t0 + 1000, 1'b0);
        btn_n[3] = 1'b0;
        watch(14, 3);
        btn_n[3] = 1'b1;
        watch(2, 3);
        btn_n[3] = 1'b0;
        watch(2, 3);
        btn_n[3] = 1'b1;
        tr = cyc + 1;
        address = 2'd0;
        for (int i = 0; i < 20 && cyc < tr + 2 + DB; i++) tick();
        check("glitch_data_still_held", {31'd0, readdata[3]}, 32'd1);
        tick();
        check("glitch_data_released", {31'd0, readdata[3]}, 32'd0);
        rd(2'd3, d);
        check("glitch_no_second_press", d, 32'h0);
        sb_empty("glitch_all_seen");

        // 6: reset while button 0 is held
        wr(2'd1, 32'hF);
        wr(2'd2, 32'h1);
        address = 2'd3;
        tick();
        t0 = cyc + 1;
        push_events(t0, t0 + 1000, 1'b0);
        btn_n[0] = 1'b0;
        watch(14, 0);
        reset = 1'b1;
        #1;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("in_reset_readdata", readdata, 32'h0);
        end
        reset = 1'b0;
        t0 = cyc + 1;
        push_events(t0, t0 + 1000, 1'b0);
        rd(2'd1, d);
        check("post_reset_mask", d, 32'h0);
        rd(2'd2, d);
        check("post_reset_repeat_en", d, 32'h0);
        watch(14, 0);
        sb_empty("post_reset_press_seen");
        check("post_reset_irq_masked", {31'd0, irq}, 32'd0);
        btn_n = '1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
